// File: rtl/avalon_mem_copy_master.sv
// Avalon-MM fill/copy initiator for a fixed-latency, no-waitrequest RAM port; fill 1 cycle/word, copy 2+READ_LATENCY.
// No backpressure: start is only sampled in IDLE, all bus outputs are registered and one DONE cycle ends each command.
module avalon_mem_copy_master #(
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   fill_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     words_done,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int CW   = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_DONE} state_t;

  state_t              r_state, w_state;
  logic                r_mode, w_mode;
  logic [ADDR_W-1:0]   r_src, w_src;
  logic [ADDR_W-1:0]   r_dst, w_dst;
  logic [ADDR_W:0]     r_len, w_len;
  logic [ADDR_W:0]     r_words, w_words;
  logic [ADDR_W:0]     w_words_inc;
  logic [DATA_W-1:0]   r_fill, w_fill;
  logic [DATA_W-1:0]   r_data, w_data;
  logic [CW-1:0]       r_wait, w_wait;
  logic                r_cs, w_cs;
  logic                r_we, w_we;
  logic [ADDR_W-1:0]   r_addr, w_addr;
  logic [DATA_W-1:0]   r_wdata, w_wdata;
  logic [BE_W-1:0]     r_be;

  assign w_words_inc = r_words + 1'b1;

  // Bus outputs are computed for the state being entered so they are registered alongside it.
  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_src   = r_src;
    w_dst   = r_dst;
    w_len   = r_len;
    w_words = r_words;
    w_fill  = r_fill;
    w_data  = r_data;
    w_wait  = r_wait;
    w_cs    = 1'b0;
    w_we    = 1'b0;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_mode  = mode;
          w_src   = src_addr;
          w_dst   = dst_addr;
          w_len   = length;
          w_fill  = fill_data;
          w_words = '0;
          if (length == '0) begin
            w_state = S_DONE;
          end else if (mode) begin
            w_state = S_RD;
            w_cs    = 1'b1;
            w_addr  = src_addr;
          end else begin
            w_state = S_WR;
            w_cs    = 1'b1;
            w_we    = 1'b1;
            w_addr  = dst_addr;
            w_wdata = fill_data;
          end
        end
      end
      S_RD: begin
        w_state = S_WAIT;
        w_wait  = '0;
      end
      S_WAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_state = S_WR;
          w_data  = mem_readdata;
          w_cs    = 1'b1;
          w_we    = 1'b1;
          w_addr  = r_dst;
          w_wdata = mem_readdata;
        end else begin
          w_wait = r_wait + 1'b1;
        end
      end
      S_WR: begin
        w_words = w_words_inc;
        w_src   = r_src + 1'b1;
        w_dst   = r_dst + 1'b1;
        if (w_words_inc == r_len) begin
          w_state = S_DONE;
        end else if (r_mode) begin
          w_state = S_RD;
          w_cs    = 1'b1;
          w_addr  = w_src;
        end else begin
          w_state = S_WR;
          w_cs    = 1'b1;
          w_we    = 1'b1;
          w_addr  = w_dst;
          w_wdata = r_fill;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_words <= '0;
      r_fill  <= '0;
      r_data  <= '0;
      r_wait  <= '0;
      r_cs    <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_src   <= w_src;
      r_dst   <= w_dst;
      r_len   <= w_len;
      r_words <= w_words;
      r_fill  <= w_fill;
      r_data  <= w_data;
      r_wait  <= w_wait;
      r_cs    <= w_cs;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_be    <= {BE_W{w_cs}};
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign done           = (r_state == S_DONE);
  assign words_done     = r_words;
  assign mem_address    = r_addr;
  assign mem_chipselect = r_cs;
  assign mem_write      = r_we;
  assign mem_byteenable = r_be;
  assign mem_writedata  = r_wdata;
endmodule
